// File: rtl/fec_decode_ctrl_if.sv
// Handshake and decoder-side signal bundle for fec_decode_ctrl.
// slave: the controller's view. master: the view of whatever drives it
// (symbol source, decoder, nibble sink, frame control).
interface fec_decode_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             frame_start;
    logic             abort;
    logic [1:0]       sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic             dec_rst;
    logic [1:0]       dec_in;
    logic             dec_en;
    logic [3:0]       dec_out;
    logic [3:0]       nib_out;
    logic             nib_valid;
    logic             nib_ready;
    logic [CNT_W-1:0] nib_cnt;
    logic             busy;
    logic             frame_done;

    modport slave (
        input  frame_start, abort, sym_in, sym_valid, dec_out, nib_ready,
        output sym_ready, dec_rst, dec_in, dec_en, nib_out, nib_valid,
               nib_cnt, busy, frame_done
    );

    modport master (
        output frame_start, abort, sym_in, sym_valid, dec_out, nib_ready,
        input  sym_ready, dec_rst, dec_in, dec_en, nib_out, nib_valid,
               nib_cnt, busy, frame_done
    );
endinterface

// File: rtl/fec_decode_ctrl.sv
// Block-decoder sequencer: feeds SYMS_PER_CW symbols, issues a trigger
// cycle, captures the corrected nibble DEC_LATENCY cycles later and hands it
// downstream. Counts FRAME_NIBBLES nibbles per frame and owns the decoder's
// synchronous reset. i_reset is asynchronous and active low.
module fec_decode_ctrl #(
    parameter int SYMS_PER_CW   = 4,
    parameter int DEC_LATENCY   = 2,
    parameter int FRAME_NIBBLES = 48,
    parameter int CNT_W         = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    fec_decode_ctrl_if.slave bus
);
    localparam int SIDX_W = $clog2(SYMS_PER_CW) + 1;
    localparam int WAIT_W = $clog2(DEC_LATENCY) + 1;

    localparam logic [SIDX_W-1:0] LAST_SYM  = SIDX_W'(SYMS_PER_CW - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(DEC_LATENCY - 1);
    localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_NIBBLES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_FEED = 3'd2;
    localparam logic [2:0] S_TRIG = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [SIDX_W-1:0] r_sym_idx;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [3:0]        r_nib_out;
    logic              r_nib_valid;
    logic [CNT_W-1:0]  r_nib_cnt;
    logic              r_frame_done;
    logic              r_dec_rst;
    logic              r_busy;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last_nib;
    logic              w_abort;
    logic              w_handshake;

    assign w_cnt_inc   = r_nib_cnt + 1'b1;
    assign w_last_nib  = (w_cnt_inc == FRAME_END);
    // Abort is meaningless in IDLE; outside IDLE it beats every other event.
    assign w_abort     = bus.abort && (r_state != S_IDLE);
    assign w_handshake = r_nib_valid && bus.nib_ready;

    // Next-state decode; abort override is applied last so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.frame_start) w_state_nxt = S_CLR;
            S_CLR:  w_state_nxt = S_FEED;
            S_FEED: if (bus.sym_valid && (r_sym_idx == LAST_SYM)) w_state_nxt = S_TRIG;
            S_TRIG: w_state_nxt = S_WAIT;
            S_WAIT: if (r_wait_cnt == LAST_WAIT) w_state_nxt = S_OUT;
            S_OUT:  if (w_handshake) w_state_nxt = w_last_nib ? S_IDLE : S_FEED;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // State plus the outputs that are pure functions of the next state,
    // registered so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_dec_rst <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dec_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLR);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Datapath: symbol/latency counters, nibble capture and hand-off, frame count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sym_idx    <= '0;
            r_wait_cnt   <= '0;
            r_nib_out    <= '0;
            r_nib_valid  <= 1'b0;
            r_nib_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_abort) begin
                // Partial codeword and any pending nibble are dropped; nib_cnt
                // is left alone so software can see how far the frame got.
                r_nib_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_CLR: begin
                        r_nib_cnt <= '0;
                        r_sym_idx <= '0;
                    end
                    S_FEED: if (bus.sym_valid) r_sym_idx <= r_sym_idx + 1'b1;
                    S_TRIG: r_wait_cnt <= '0;
                    S_WAIT: begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == LAST_WAIT) begin
                            r_nib_out   <= bus.dec_out;
                            r_nib_valid <= 1'b1;
                        end
                    end
                    S_OUT: if (w_handshake) begin
                        r_nib_valid <= 1'b0;
                        r_nib_cnt   <= w_cnt_inc;
                        if (w_last_nib) r_frame_done <= 1'b1;
                        else            r_sym_idx    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Symbol path is combinational so an accepted symbol reaches the decoder
    // in the same cycle; TRIG enables the decoder with no symbol.
    assign bus.sym_ready  = (r_state == S_FEED);
    assign bus.dec_en     = ((r_state == S_FEED) && bus.sym_valid) || (r_state == S_TRIG);
    assign bus.dec_in     = bus.sym_in;
    assign bus.dec_rst    = r_dec_rst;
    assign bus.nib_out    = r_nib_out;
    assign bus.nib_valid  = r_nib_valid;
    assign bus.nib_cnt    = r_nib_cnt;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule
